// File: rtl/mult_share_ctrl.sv
// Round-robin two-port sequencer in front of the shared shift-add multiplier.
// Optional watchdog on the multiplier completion: define MULT_SHARE_TIMEOUT_EN.
module mult_share_ctrl #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     op_a0,
    input  logic [WIDTH-1:0]     op_b0,
    input  logic [WIDTH-1:0]     op_a1,
    input  logic [WIDTH-1:0]     op_b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_id,
    output logic [2*WIDTH-1:0]   res_prod,
    output logic                 res_err,
    output logic                 busy,
    output logic                 mul_st,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_idle,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_prod
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 id_q, id_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic                 gnt;
    logic                 grant_valid;
    logic [1:0]           req_vec;
    logic [1:0]           ack_vec;
    logic [WIDTH-1:0]     op_a_vec [0:1];
    logic [WIDTH-1:0]     op_b_vec [0:1];

`ifdef MULT_SHARE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
`else
    logic                 unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    assign req_vec     = {req1, req0};
    assign op_a_vec[0] = op_a0;
    assign op_a_vec[1] = op_a1;
    assign op_b_vec[0] = op_b0;
    assign op_b_vec[1] = op_b1;

    // On a tie the requester not served last wins; a lone request always wins.
    assign gnt = (req0 & req1) ? ~last_gnt_q : req1;

    // Acks are combinational so they line up with the operand capture edge;
    // gating with rst_n keeps them low while reset is held.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign ack_vec[gi] = grant_valid & (gnt == 1'(gi)) & rst_n;
    end

    assign ack0 = ack_vec[0];
    assign ack1 = ack_vec[1];

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        grant_valid = 1'b0;
        mul_st      = 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_vec) begin
                    grant_valid = 1'b1;
                    id_d        = gnt;
                    a_d         = op_a_vec[gnt];
                    b_d         = op_b_vec[gnt];
                    state_d     = S_START;
                end
            end
            S_START: begin
                // Never start over a multiplication still in flight.
                if (mul_idle) begin
                    mul_st  = 1'b1;
                    state_d = S_WAIT;
`ifdef MULT_SHARE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    prod_d  = mul_prod;
                    state_d = S_RESP;
`ifdef MULT_SHARE_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    last_gnt_d = id_q;
                    state_d    = S_IDLE;
`ifdef MULT_SHARE_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
`ifdef MULT_SHARE_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            prod_q     <= prod_d;
`ifdef MULT_SHARE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_RESP);
    assign res_id    = id_q;
    assign res_prod  = prod_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
`ifdef MULT_SHARE_TIMEOUT_EN
    assign res_err   = err_q;
`else
    assign res_err   = 1'b0;
`endif

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencer and two-port arbiter for the shared 16x16 shift-add multiplier. It accepts operand requests from two requesters, grants them round-robin, and issues the start pulse to the multiplier. It then waits for the multiplier's completion strobe and returns the 32-bit product with the winning requester's ID over a valid/ready result handshake. It sits between the ALU-side issue logic and the multiplier, and is the only block allowed to drive the multiplier's start input.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH.
- TIMEOUT_CYCLES, 64, watchdog limit; used only when the watchdog is compiled in.

- Clk  in  1  rising-edge clock; single clock domain.
- Rst_n  in  1  asynchronous, active-low reset.
- Req0 / Req1  in  1  request from requester 0/1; held until Ack.
- OpA0, OpB0 / OpA1, OpB1  in  WIDTH  operands; sampled in the Ack cycle.
- Ack0 / Ack1  out  1  one-cycle pulse: request accepted, operands latched.
- Res_Valid  out  1  result available.
- Res_Ready  in  1  consumer accepts the result.
- Res_Id  out  1  ID of the requester that owns the result.
- Res_Prod  out  2*WIDTH  product.
- Res_Err  out  1  watchdog expired; Res_Prod=0. Tied 0 when the watchdog is compiled out.
- Busy  out  1  FSM not in IDLE.
- Mul_St  out  1  start strobe to the multiplier.
- Mul_A, Mul_B  out  WIDTH  multiplicand and multiplier operands; held stable from START until exit from WAIT.
- Mul_Idle, Mul_Done  in  1  multiplier status.
- Mul_Prod  in  2*WIDTH  multiplier product; valid in the Mul_Done cycle.

## Operation
- FSM has four states: IDLE, START, WAIT, RESP.
- IDLE
  - Only one request pending: grant it.
  - Both pending: grant the requester that is not the last one served (Last_Gnt).
  - In the grant cycle: pulse Ack of the granted requester, latch its operands into Mul_A/Mul_B, latch its ID, go to START.
- START
  - Assert Mul_St only while Mul_Idle=1; otherwise hold in START with Mul_St=0.
  - After the cycle with Mul_St=1 and Mul_Idle=1, go to WAIT.
- WAIT
  - Mul_St=0.
  - On Mul_Done=1: register Mul_Prod into Res_Prod and go to RESP.
- RESP
  - Res_Valid=1; Res_Id, Res_Prod and Res_Err are held stable.
  - On Res_Valid & Res_Ready: update Last_Gnt to Res_Id and go to IDLE.
- Requests arriving while not in IDLE get no Ack. They stay pending and are arbitrated on return to IDLE; at most one Ack per transaction.
- Mul_Done seen in IDLE, START or RESP is ignored (stale completion).
- Product width: Res_Prod = Mul_Prod[2*WIDTH-1:0], no truncation or sign handling (unsigned).

## Timing
- Reset values: Ack0=Ack1=0, Res_Valid=0, Res_Id=0, Res_Prod=0, Res_Err=0, Busy=0, Mul_St=0, Mul_A=Mul_B=0, FSM=IDLE, Last_Gnt=1 (so requester 0 wins the first tie).
- Latency with Mul_Idle=1 at grant:
  - Ack in cycle T.
  - Mul_St in T+1.
  - Res_Valid from the cycle after Mul_Done.
- Back-to-back: RESP exits to IDLE, and a new grant occurs no earlier than the following cycle. Minimum spacing between Acks is 4 cycles plus multiplier latency.
- Reset mid-operation: all outputs return to reset values immediately (async). After reset release, START waits for Mul_Idle, so an in-flight multiplication is never restarted early. Its Done is discarded.
- Res_Ready held high continuously: the result is consumed in the first RESP cycle.

## Configuration
- MULT_SHARE_TIMEOUT_EN
  - Defined: a counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without Mul_Done, go to RESP with Res_Err=1 and Res_Prod=0. A later Mul_Done is ignored.
  - Undefined: no counter; WAIT holds indefinitely; Res_Err is constant 0.

## Test plan
- Single request: Req0, OpA0=16'd3, OpB0=16'd7 -> Ack0 one cycle, Mul_St one cycle later, then Res_Valid with Res_Prod=32'd21, Res_Id=0.
- Tie after reset: Req0 and Req1 both high, 0xFFFF*0xFFFF and 2*5 -> requester 0 first (Res_Prod=32'hFFFE0001, Res_Id=0), then requester 1 (Res_Prod=32'd10, Res_Id=1).
- Backpressure: Res_Ready low for 5 cycles -> Res_Valid, Res_Prod and Res_Id stable throughout; Req1 raised meanwhile gets no Ack until after the handshake.
- Multiplier not idle: Mul_Idle=0 for 3 cycles after Ack -> Mul_St stays 0, then asserts in the first Mul_Idle=1 cycle; a spurious Mul_Done during START is ignored.
- Reset mid-WAIT: Rst_n low for 1 cycle -> all outputs at reset values asynchronously; next request completes correctly with the right product.
- With MULT_SHARE_TIMEOUT_EN and TIMEOUT_CYCLES=8: Mul_Done withheld -> after 8 WAIT cycles, Res_Valid=1, Res_Err=1, Res_Prod=0; a late Mul_Done is ignored.
